// File: rtl/rv_multicycle_ctrl.sv
// ============================================================================
// Module   : rv_multicycle_ctrl
// Purpose  : Multi-cycle control sequencer for the RV32I core. Steps each
//            instruction through FETCH, DECODE, EXEC, MEM and WB, drives the
//            datapath strobes and immediate-format select, runs the memory
//            req/ack handshake, halts on SYSTEM/illegal opcodes and counts
//            retired instructions.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1   core clock, rising edge
//   rst_n         in   1   synchronous active-low reset
//   instr         in  32   IR contents, valid from DECODE onward
//   branch_taken  in   1   comparator result, sampled in EXEC
//   mem_ack       in   1   memory completion for the current request
//   mem_req       out  1   memory request, held until mem_ack
//   mem_we        out  1   store qualifier (MEM only)
//   ir_we         out  1   latch instruction from memory data
//   pc_we         out  1   update PC
//   pc_src        out  2   0 pc+4, 1 pc+imm, 2 ALU (JALR)
//   rf_we         out  1   register-file write
//   wb_sel        out  2   0 ALU, 1 load data, 2 pc+4
//   alu_a_sel     out  2   0 rs1, 1 pc, 2 zero
//   alu_b_sel     out  1   0 rs2, 1 imm
//   imm_sel       out  3   0 I, 1 S, 2 B, 3 U, 4 J, 7 none
//   halted        out  1   in HALT
//   retire        out  1   one-cycle pulse per completed instruction
//   instret       out 32   retired-instruction count
// ============================================================================
`default_nettype none

module rv_multicycle_ctrl #(
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [2:0]  imm_sel,
  output logic        halted,
  output logic        retire,
  output logic [31:0] instret
);

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OP_OP     = 7'b0110011;
  localparam logic [6:0] c_OP_FENCE  = 7'b0001111;

  localparam logic [2:0] c_IMM_I    = 3'd0;
  localparam logic [2:0] c_IMM_S    = 3'd1;
  localparam logic [2:0] c_IMM_B    = 3'd2;
  localparam logic [2:0] c_IMM_U    = 3'd3;
  localparam logic [2:0] c_IMM_J    = 3'd4;
  localparam logic [2:0] c_IMM_NONE = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam state_t c_RESET_STATE = RESET_STATE_FETCH ? S_FETCH : S_HALT;

  state_t      state_q, state_d;
  logic        in_reset_q;   // last edge sampled rst_n low
  logic [31:0] instret_q;
  logic [6:0]  opcode;
  logic [2:0]  imm_dec;
  logic        legal;
  logic        unused_instr_hi;

  assign opcode          = instr[6:0];
  assign unused_instr_hi = ^instr[31:7];
  assign instret         = instret_q;

  // Opcode classification: immediate format and legality.
  always_comb begin
    imm_dec = c_IMM_NONE;
    legal   = 1'b1;
    case (opcode)
      c_OP_LUI, c_OP_AUIPC:             imm_dec = c_IMM_U;
      c_OP_JAL:                         imm_dec = c_IMM_J;
      c_OP_JALR, c_OP_LOAD, c_OP_OPIMM: imm_dec = c_IMM_I;
      c_OP_STORE:                       imm_dec = c_IMM_S;
      c_OP_BRANCH:                      imm_dec = c_IMM_B;
      c_OP_OP, c_OP_FENCE:              imm_dec = c_IMM_NONE;
      default:                          legal   = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= c_RESET_STATE;
      in_reset_q <= 1'b1;
      instret_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      in_reset_q <= 1'b0;
      if (retire) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    alu_a_sel = 2'd0;
    alu_b_sel = 1'b0;
    imm_sel   = c_IMM_NONE;
    halted    = 1'b0;
    retire    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        imm_sel = imm_dec;
        state_d = legal ? S_EXEC : S_HALT;
      end

      S_EXEC: begin
        imm_sel = imm_dec;
        state_d = S_WB;
        case (opcode)
          c_OP_OP: ;
          c_OP_OPIMM, c_OP_JALR: alu_b_sel = 1'b1;
          c_OP_LOAD, c_OP_STORE: begin
            alu_b_sel = 1'b1;
            state_d   = S_MEM;
          end
          c_OP_AUIPC: begin
            alu_a_sel = 2'd1;
            alu_b_sel = 1'b1;
          end
          c_OP_LUI: begin
            alu_a_sel = 2'd2;
            alu_b_sel = 1'b1;
          end
          c_OP_JAL: ;
          c_OP_BRANCH: begin
            pc_we   = 1'b1;
            pc_src  = branch_taken ? 2'd1 : 2'd0;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          c_OP_FENCE: begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end

      S_MEM: begin
        imm_sel = imm_dec;
        mem_req = 1'b1;
        mem_we  = (opcode == c_OP_STORE);
        if (mem_ack) begin
          if (opcode == c_OP_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end

      S_WB: begin
        imm_sel = imm_dec;
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        if (opcode == c_OP_LOAD) begin
          wb_sel = 2'd1;
        end else if (opcode == c_OP_JAL || opcode == c_OP_JALR) begin
          wb_sel = 2'd2;
        end
        if (opcode == c_OP_JAL) begin
          pc_src = 2'd1;
        end else if (opcode == c_OP_JALR) begin
          pc_src = 2'd2;
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: state_d = c_RESET_STATE;
    endcase

    // While reset is being applied the block is quiet and frozen; this also
    // swallows any late mem_ack from a request cut short by reset.
    if (in_reset_q) begin
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'd0;
      rf_we     = 1'b0;
      wb_sel    = 2'd0;
      alu_a_sel = 2'd0;
      alu_b_sel = 1'b0;
      imm_sel   = c_IMM_NONE;
      halted    = 1'b0;
      retire    = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_rv_multicycle_ctrl
// Purpose  : Self-checking bench for rv_multicycle_ctrl. Instructions are run
//            one at a time with a memory responder that inserts chosen wait
//            states; a per-opcode reference table predicts latency, strobe
//            counts and key select values for each instruction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        branch_taken;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel;
  logic [2:0]  imm_sel;
  logic        halted;
  logic        retire;
  logic [31:0] instret;

  int          n_vec;
  int          n_err;
  logic [31:0] model_instret;

  rv_multicycle_ctrl #(.RESET_STATE_FETCH(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .branch_taken (branch_taken),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .imm_sel      (imm_sel),
    .halted       (halted),
    .retire       (retire),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference table: what the architecture says each opcode class does.
  // legal, imm format, uses memory, is store, writes rf, ALU a/b selects,
  // wb_sel and pc_src of the final cycle, zero-wait latency.
  typedef struct {
    bit       legal;
    int       imm;
    bit       mem;
    bit       store;
    bit       rf;
    int       a;
    int       b;
    int       wb;
    int       src;
    int       base;
  } ref_t;

  function automatic ref_t ref_of(input logic [6:0] op, input bit taken);
    ref_t r;
    r = '{legal:1, imm:7, mem:0, store:0, rf:1, a:0, b:0, wb:0, src:0, base:4};
    case (op)
      7'b0110011: ;                                                  // OP
      7'b0010011: begin r.imm = 0; r.b = 1; end                      // OP-IMM
      7'b0000011: begin r.imm = 0; r.b = 1; r.mem = 1; r.wb = 1; r.base = 5; end
      7'b0100011: begin r.imm = 1; r.b = 1; r.mem = 1; r.store = 1; r.rf = 0; end
      7'b1100111: begin r.imm = 0; r.b = 1; r.wb = 2; r.src = 2; end // JALR
      7'b0010111: begin r.imm = 3; r.a = 1; r.b = 1; end             // AUIPC
      7'b0110111: begin r.imm = 3; r.a = 2; r.b = 1; end             // LUI
      7'b1101111: begin r.imm = 4; r.wb = 2; r.src = 1; end          // JAL
      7'b1100011: begin r.imm = 2; r.rf = 0; r.base = 3; r.src = taken ? 1 : 0; end
      7'b0001111: begin r.rf = 0; r.base = 3; end                    // FENCE
      default:    r.legal = 0;
    endcase
    return r;
  endfunction

  // Enters and leaves 1 time unit after a rising edge; leaves in FETCH.
  task automatic do_reset();
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    chk_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk_eq("rst_imm_sel", {29'd0, imm_sel}, 32'd7);
    chk_eq("rst_halted",  {31'd0, halted},  32'd0);
    chk_eq("rst_strobes", {26'd0, pc_we, rf_we, ir_we, mem_we, retire, alu_b_sel}, 32'd0);
    chk_eq("rst_sels",    {26'd0, pc_src, wb_sel, alu_a_sel}, 32'd0);
    @(posedge clk); #1;
    chk_eq("rst_instret", instret, 32'd0);
    rst_n = 1'b1;
    model_instret = 32'd0;
    @(posedge clk); #1;
  endtask

  // Runs one instruction from its FETCH cycle. fw/mw are the wait cycles the
  // memory inserts before acking the fetch and the data access.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input bit taken);
    ref_t r;
    int   cyc, run, ridx;
    int   n_req, n_we, n_ir, n_rf, n_pc, n_ret, n_hreq, n_hstb;
    int   dec_imm, ex_a, ex_b, fin_src, fin_wb, fin_imm, lat;
    bit   done, saw_halt;
    r = ref_of(ins[6:0], taken);
    instr = ins; branch_taken = taken;
    run = 0; ridx = 0; n_req = 0; n_we = 0; n_ir = 0; n_rf = 0; n_pc = 0; n_ret = 0;
    dec_imm = -1; ex_a = -1; ex_b = -1; fin_src = -1; fin_wb = -1; fin_imm = -1;
    lat = -1; saw_halt = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (mem_req) mem_ack = (run == ((ridx == 0) ? fw : mw));
      else         mem_ack = 1'($urandom_range(0, 1));
      #1;
      n_req += int'(mem_req); n_we += int'(mem_we); n_ir += int'(ir_we);
      n_rf  += int'(rf_we);   n_pc += int'(pc_we);  n_ret += int'(retire);
      if (cyc == fw + 1) dec_imm = int'(imm_sel);
      if (cyc == fw + 2) begin ex_a = int'(alu_a_sel); ex_b = int'(alu_b_sel); end
      if (pc_we) begin fin_src = int'(pc_src); fin_wb = int'(wb_sel); fin_imm = int'(imm_sel); end
      saw_halt = halted;
      if (mem_req) begin
        if (mem_ack) begin run = 0; ridx++; end
        else run++;
      end
      done = retire || halted;
      @(posedge clk); #1;
      if (done) begin lat = cyc + 1; break; end
    end
    mem_ack = 1'b0;
    if (r.legal) begin
      model_instret = model_instret + 32'd1;
      chk_eq("latency",   lat,     r.base + fw + (r.mem ? mw : 0));
      chk_eq("req_cyc",   n_req,   fw + 1 + (r.mem ? mw + 1 : 0));
      chk_eq("we_cyc",    n_we,    r.store ? mw + 1 : 0);
      chk_eq("ir_we_cnt", n_ir,    1);
      chk_eq("rf_we_cnt", n_rf,    int'(r.rf));
      chk_eq("pc_we_cnt", n_pc,    1);
      chk_eq("retire_cnt", n_ret,  1);
      chk_eq("dec_imm",   dec_imm, r.imm);
      chk_eq("alu_a",     ex_a,    r.a);
      chk_eq("alu_b",     ex_b,    r.b);
      chk_eq("pc_src",    fin_src, r.src);
      chk_eq("wb_sel",    fin_wb,  r.wb);
      chk_eq("fin_imm",   fin_imm, r.imm);
      chk_eq("instret",   instret, model_instret);
    end else begin
      chk_eq("halt_lat",  lat,      fw + 3);
      chk_eq("halt_flag", {31'd0, saw_halt}, 32'd1);
      chk_eq("halt_dec_imm", dec_imm, 7);
      chk_eq("halt_noret", n_ret + n_pc + n_rf, 0);
      // Sticky: random acks must not wake it up.
      n_hreq = 0; n_hstb = 0;
      for (int k = 0; k < 5; k++) begin
        mem_ack = 1'($urandom_range(0, 1));
        #1;
        n_hreq += int'(mem_req);
        n_hstb += int'(pc_we) + int'(rf_we) + int'(ir_we) + int'(retire) + int'(!halted)
                + int'(imm_sel != 3'd7);
        @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      chk_eq("halt_req",     n_hreq,  0);
      chk_eq("halt_strobes", n_hstb,  0);
      chk_eq("halt_instret", instret, model_instret);
      do_reset();
    end
  endtask

  function automatic logic [6:0] pick_op(input int k);
    logic [6:0] tbl [10];
    logic [6:0] op;
    tbl = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100111,
            7'b0010111, 7'b0110111, 7'b1101111, 7'b1100011, 7'b0001111};
    if (k < 10) return tbl[k];
    if (k == 10) return 7'b1110011;
    do begin
      op = 7'($urandom);
    end while (ref_of(op, 1'b0).legal);
    return op;
  endfunction

  initial begin
    n_vec = 0; n_err = 0; model_instret = 32'd0;
    rst_n = 1'b0; instr = 32'd0; branch_taken = 1'b0; mem_ack = 1'b0;

    do_reset();

    // Directed cases.
    run_instr(32'h0050_0093, 0, 0, 1'b0);  // ADDI x1, x0, 5
    run_instr(32'h0001_2083, 0, 2, 1'b0);  // LW, data ack after 2 waits
    run_instr(32'h0000_0463, 0, 0, 1'b1);  // BEQ taken
    run_instr(32'h0000_0463, 1, 0, 1'b0);  // BEQ not taken, fetch wait
    run_instr(32'h0011_2023, 0, 1, 1'b0);  // SW
    run_instr(32'h0080_00EF, 0, 0, 1'b0);  // JAL
    run_instr(32'h0000_007F, 0, 0, 1'b0);  // illegal opcode
    run_instr(32'h0000_0073, 1, 0, 1'b0);  // ECALL

    // Reset during MEM with ack following in the reset cycle.
    instr = 32'h0001_2083;
    model_instret = 32'd0;
    #1; mem_ack = 1'b1; @(posedge clk); #1;   // FETCH
    mem_ack = 1'b0;     @(posedge clk); #1;   // DECODE
    @(posedge clk); #1;                       // EXEC
    chk_eq("mid_mem_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;       @(posedge clk); #1;
    mem_ack = 1'b1; #1;
    chk_eq("mid_rst_req",    {31'd0, mem_req}, 32'd0);
    chk_eq("mid_rst_retire", {31'd0, retire},  32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0; rst_n = 1'b1;
    chk_eq("mid_rel_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    chk_eq("mid_first_req", {31'd0, mem_req}, 32'd1);
    chk_eq("mid_instret",   instret, 32'd0);
    run_instr(32'h0050_0093, 0, 0, 1'b0);

    // Counter wrap.
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    model_instret = 32'hFFFF_FFFF;
    chk_eq("wrap_preload", instret, 32'hFFFF_FFFF);
    run_instr(32'h0000_000F, 0, 0, 1'b0);  // FENCE, wraps to 0

    // Randomized instruction stream.
    for (int i = 0; i < 60; i++) begin
      int k;
      logic [31:0] ins;
      k = int'($urandom_range(0, 21));
      if (k > 11) k = k - 12;               // bias toward legal opcodes
      ins = {25'($urandom), pick_op(k)};
      run_instr(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
